// File: rtl/led_blink_pkg.sv
// rtl/led_blink_pkg.sv - shared state type and default terminal counts for the LED blink controller
package led_blink_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 27;
    localparam int TC0_DEF   = 12_499_999;
    localparam int TC1_DEF   = 24_999_999;
    localparam int TC2_DEF   = 49_999_999;
    localparam int TC3_DEF   = 99_999_999;

endpackage

// File: rtl/led_blink_ctrl_if.sv
// rtl/led_blink_ctrl_if.sv - control/status bundle between switch logic and the LED blink controller
interface led_blink_ctrl_if;
    import led_blink_pkg::*;

    logic [1:0] switch;
    logic       enable;
    logic       burst_start;
    logic [3:0] burst_len;
    logic       led;
    logic       busy;
    logic       period_tick;
    logic [1:0] rate_q;

    modport master (
        output switch, enable, burst_start, burst_len,
        input  led, busy, period_tick, rate_q
    );

    modport slave (
        input  switch, enable, burst_start, burst_len,
        output led, busy, period_tick, rate_q
    );

endinterface

// File: rtl/led_blink_ctrl_prescaler.sv
// rtl/led_blink_ctrl_prescaler.sv - half-period prescale counter with rate-selected terminal count
module blink_prescaler
    import led_blink_pkg::*;
#(
    parameter int             CNT_W = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TC0 = CNT_W'(TC0_DEF),
    parameter logic [CNT_W-1:0] TC1 = CNT_W'(TC1_DEF),
    parameter logic [CNT_W-1:0] TC2 = CNT_W'(TC2_DEF),
    parameter logic [CNT_W-1:0] TC3 = CNT_W'(TC3_DEF)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [1:0] sel,
    output logic       tc_hit
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] tc_sel;

    always_comb begin
        case (sel)
            2'd0:    tc_sel = TC0;
            2'd1:    tc_sel = TC1;
            2'd2:    tc_sel = TC2;
            default: tc_sel = TC3;
        endcase
    end

    // >= so that a count left above a smaller terminal count still wraps
    assign tc_hit = (cnt >= tc_sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || tc_hit) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_blink_ctrl.sv
// rtl/led_blink_ctrl.sv - OFF/RUN/BURST sequencer driving the LED from the shared prescaler
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter int             CNT_W = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TC0 = CNT_W'(TC0_DEF),
    parameter logic [CNT_W-1:0] TC1 = CNT_W'(TC1_DEF),
    parameter logic [CNT_W-1:0] TC2 = CNT_W'(TC2_DEF),
    parameter logic [CNT_W-1:0] TC3 = CNT_W'(TC3_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    led_blink_ctrl_if.slave  bus
);

    state_t     state, state_n;
    logic       led_q, led_n;
    logic       tick_q, tick_n;
    logic [1:0] rate_q, rate_n;
    logic [3:0] burst_cnt, burst_cnt_n;
    logic [3:0] len_q, len_n;
    logic       clear;
    logic       tc_hit;

    blink_prescaler #(
        .CNT_W (CNT_W),
        .TC0   (TC0),
        .TC1   (TC1),
        .TC2   (TC2),
        .TC3   (TC3)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .sel    (rate_q),
        .tc_hit (tc_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_OFF;
            led_q     <= 1'b0;
            tick_q    <= 1'b0;
            rate_q    <= 2'd0;
            burst_cnt <= 4'd0;
            len_q     <= 4'd0;
        end else begin
            state     <= state_n;
            led_q     <= led_n;
            tick_q    <= tick_n;
            rate_q    <= rate_n;
            burst_cnt <= burst_cnt_n;
            len_q     <= len_n;
        end
    end

    always_comb begin
        state_n     = state;
        led_n       = led_q;
        tick_n      = 1'b0;
        rate_n      = rate_q;
        burst_cnt_n = burst_cnt;
        len_n       = len_q;
        clear       = 1'b0;

        case (state)
            ST_OFF: begin
                clear = 1'b1;
                led_n = 1'b0;
                if (bus.burst_start) begin
                    state_n     = ST_BURST;
                    rate_n      = bus.switch;
                    burst_cnt_n = 4'd0;
                    len_n       = bus.burst_len;
                end else if (bus.enable) begin
                    state_n     = ST_RUN;
                    rate_n      = bus.switch;
                    burst_cnt_n = 4'd0;
                end
            end

            ST_RUN: begin
                if (!bus.enable) begin
                    state_n = ST_OFF;
                    led_n   = 1'b0;
                    clear   = 1'b1;
                end else if (tc_hit) begin
                    led_n  = ~led_q;
                    tick_n = 1'b1;
                    rate_n = bus.switch;
                end
            end

            ST_BURST: begin
                // Exit is evaluated the cycle after the final falling toggle, which
                // also gives a zero-length burst its single BURST cycle.
                if (burst_cnt == len_q) begin
                    state_n = ST_OFF;
                    led_n   = 1'b0;
                    clear   = 1'b1;
                end else if (tc_hit) begin
                    led_n  = ~led_q;
                    tick_n = 1'b1;
                    rate_n = bus.switch;
                    if (led_q) begin
                        burst_cnt_n = burst_cnt + 4'd1;
                    end
                end
            end

            default: begin
                state_n = ST_OFF;
                led_n   = 1'b0;
                clear   = 1'b1;
            end
        endcase
    end

    assign bus.led         = led_q;
    assign bus.busy        = (state == ST_BURST);
    assign bus.period_tick = tick_q;
    assign bus.rate_q      = rate_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// tb/tb_led_blink_ctrl.sv - self-checking bench for led_blink_ctrl with small terminal counts
module tb_led_blink_ctrl;

    logic clk;
    logic reset;

    led_blink_ctrl_if bus();

    led_blink_ctrl #(
        .CNT_W (27),
        .TC0   (27'd3),
        .TC1   (27'd7),
        .TC2   (27'd15),
        .TC3   (27'd31)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: countdown of cycles left in the current half-period.
    int         m_mode;     // 0 off, 1 run, 2 burst
    logic       m_led;
    logic       m_tick;
    logic [1:0] m_rate;
    int         m_left;
    int         m_blinks;

    function automatic int half_len(input logic [1:0] s);
        return 4 << s;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_led = 1'b0; m_tick = 1'b0; m_rate = 2'd0;
        m_left = 0; m_blinks = 0;
    endtask

    task automatic model_advance();
        m_left = m_left - 1;
        if (m_left == 0) begin
            m_led  = ~m_led;
            m_tick = 1'b1;
            m_rate = bus.switch;
            m_left = half_len(bus.switch);
        end
    endtask

    task automatic model_step();
        m_tick = 1'b0;
        case (m_mode)
            0: begin
                m_led = 1'b0;
                if (bus.burst_start) begin
                    m_mode = 2; m_rate = bus.switch;
                    m_left = half_len(bus.switch); m_blinks = bus.burst_len;
                end else if (bus.enable) begin
                    m_mode = 1; m_rate = bus.switch;
                    m_left = half_len(bus.switch);
                end
            end
            1: begin
                if (!bus.enable) begin m_mode = 0; m_led = 1'b0; end
                else model_advance();
            end
            default: begin
                if (m_blinks == 0) begin m_mode = 0; m_led = 1'b0; end
                else begin
                    model_advance();
                    if (m_tick && !m_led) m_blinks = m_blinks - 1;
                end
            end
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("model_led",  bus.led,         m_led);
        chk("model_busy", bus.busy,        (m_mode == 2));
        chk("model_tick", bus.period_tick, m_tick);
        chk("model_rate", bus.rate_q,      m_rate);
    endtask

    task automatic do_reset();
        bus.enable = 1'b0; bus.burst_start = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.period_tick && n < 200);
        chk("tick_seen", bus.period_tick, 1);
    endtask

    typedef struct {
        logic [1:0] sw;
        logic       en;
        logic       bs;
        logic [3:0] len;
        int         cycles;
        int         ticks;
        int         busy;
        logic       led;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n, ticks, busy_n;

        vecs[0] = '{2'd1, 1'b0, 1'b1, 4'd3, 60, 6, 49, 1'b0};
        vecs[1] = '{2'd2, 1'b0, 1'b1, 4'd0, 20, 0,  1, 1'b0};
        vecs[2] = '{2'd0, 1'b1, 1'b0, 4'd0, 20, 5,  0, 1'b1};
        vecs[3] = '{2'd1, 1'b1, 1'b0, 4'd0, 40, 5,  0, 1'b1};
        vecs[4] = '{2'd0, 1'b1, 1'b1, 4'd2, 30, 7, 17, 1'b1};
        vecs[5] = '{2'd3, 1'b1, 1'b0, 4'd0, 64, 2,  0, 1'b0};

        reset = 1'b1;
        bus.switch = 2'd0; bus.enable = 1'b0; bus.burst_start = 1'b0; bus.burst_len = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_led",  bus.led, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tick", bus.period_tick, 0);
        chk("rst_rate", bus.rate_q, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_reset();
            bus.switch = vecs[i].sw; bus.enable = vecs[i].en;
            bus.burst_start = vecs[i].bs; bus.burst_len = vecs[i].len;
            step();
            bus.burst_start = 1'b0;
            ticks  = bus.period_tick;
            busy_n = bus.busy;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                step();
                ticks  += bus.period_tick;
                busy_n += bus.busy;
            end
            chk($sformatf("vec%0d_ticks", i), ticks, vecs[i].ticks);
            chk($sformatf("vec%0d_busy", i), busy_n, vecs[i].busy);
            chk($sformatf("vec%0d_led", i), bus.led, vecs[i].led);
        end

        // Rate change one cycle after a toggle takes effect only at the next toggle.
        do_reset();
        bus.switch = 2'd0; bus.enable = 1'b1;
        step();
        wait_tick(n);
        chk("first_rise", n, 4);
        step();
        bus.switch = 2'd3;
        wait_tick(n);
        chk("half_after_switch", n + 1, 4);
        chk("rate_after_toggle", bus.rate_q, 3);
        wait_tick(n);
        chk("slow_half", n, 32);

        // Asynchronous reset in the middle of a toggle cycle.
        do_reset();
        bus.switch = 2'd2; bus.enable = 1'b1;
        step();
        wait_tick(n);
        chk("pre_rst_led", bus.led, 1);
        chk("pre_rst_rate", bus.rate_q, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_led",  bus.led, 0);
        chk("async_busy", bus.busy, 0);
        chk("async_tick", bus.period_tick, 0);
        chk("async_rate", bus.rate_q, 0);
        bus.enable = 1'b0;
        step();
        reset = 1'b0;
        step(); step();
        chk("post_rst_led", bus.led, 0);

        // Enable dropped mid-half-period.
        do_reset();
        bus.switch = 2'd1; bus.enable = 1'b1;
        step();
        wait_tick(n);
        step(); step(); step();
        bus.enable = 1'b0;
        step();
        chk("drop_led", bus.led, 0);
        chk("drop_tick", bus.period_tick, 0);
        step(); step();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(0, 9) == 0)  bus.switch = 2'($urandom_range(0, 3));
            bus.burst_start = ($urandom_range(0, 29) == 0);
            bus.burst_len   = 4'($urandom_range(0, 5));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
